avs_avalonslave_control: RTL and testbench

AVS_AVALONSLAVE_CONTROL -- requirements
Module: avs_avalonslave_control

---
 rtl/avs_avalonslave_control.sv | 195 +++++++++++++++++++
 tb/tb_avs_avalonslave_control.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avs_avalonslave_control.sv
// Avalon-MM CSR slave and run controller for a vector accelerator.
// It holds the operand registers, issues a one-cycle GO, counts busy cycles and raises a completion IRQ.
module avs_avalonslave_control #(
    parameter int AVS_AVALONSLAVE_DATA_WIDTH    = 32,
    parameter int AVS_AVALONSLAVE_ADDRESS_WIDTH = 3
) (
    input  logic                                       CSI_CLOCK_CLK,
    input  logic                                       CSI_CLOCK_RESET,
    input  logic [AVS_AVALONSLAVE_ADDRESS_WIDTH-1:0]   AVS_AVALONSLAVE_ADDRESS,
    input  logic                                       AVS_AVALONSLAVE_READ,
    input  logic                                       AVS_AVALONSLAVE_WRITE,
    input  logic [AVS_AVALONSLAVE_DATA_WIDTH-1:0]      AVS_AVALONSLAVE_WRITEDATA,
    input  logic [AVS_AVALONSLAVE_DATA_WIDTH/8-1:0]    AVS_AVALONSLAVE_BYTEENABLE,
    output logic [AVS_AVALONSLAVE_DATA_WIDTH-1:0]      AVS_AVALONSLAVE_READDATA,
    output logic                                       AVS_AVALONSLAVE_WAITREQUEST,
    output logic                                       INS_IRQ_IRQ,
    output logic                                       GO,
    input  logic                                       DONE,
    output logic [AVS_AVALONSLAVE_DATA_WIDTH-1:0]      SLV_REG1,
    output logic [AVS_AVALONSLAVE_DATA_WIDTH-1:0]      SLV_REG2,
    output logic [AVS_AVALONSLAVE_DATA_WIDTH-1:0]      SLV_REG3,
    output logic [18:0]                                SIZE,
    output logic [10:0]                                NUMBER
);

    localparam int DW       = AVS_AVALONSLAVE_DATA_WIDTH;
    localparam int AW       = AVS_AVALONSLAVE_ADDRESS_WIDTH;
    localparam int BW       = DW / 8;
    localparam int SIZE_W   = 19;
    localparam int NUMBER_W = 11;

    localparam logic [AW-1:0] ADDR_CTRL   = AW'(0);
    localparam logic [AW-1:0] ADDR_STATUS = AW'(1);
    localparam logic [AW-1:0] ADDR_SRC_A  = AW'(2);
    localparam logic [AW-1:0] ADDR_SRC_B  = AW'(3);
    localparam logic [AW-1:0] ADDR_DST    = AW'(4);
    localparam logic [AW-1:0] ADDR_SIZE   = AW'(5);
    localparam logic [AW-1:0] ADDR_NUMBER = AW'(6);
    localparam logic [AW-1:0] ADDR_CYCLES = AW'(7);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_BUSY  = 2'd2;

    logic [1:0]          state;
    logic                irq_en;
    logic                done_sticky;
    logic [DW-1:0]       src_a;
    logic [DW-1:0]       src_b;
    logic [DW-1:0]       dst;
    logic [SIZE_W-1:0]   size_reg;
    logic [NUMBER_W-1:0] number_reg;
    logic [DW-1:0]       cycles;
    logic [DW-1:0]       readdata;
    logic [DW-1:0]       rd_mux;
    logic                go_reg;
    logic                irq_reg;

    logic busy;
    logic wr_ctrl;
    logic wr_status;
    logic operand_wr;
    logic start_req;
    logic done_hit;
    logic status_w1c;

    // Replace only the byte lanes enabled for this write.
    function automatic logic [DW-1:0] merge_lanes(input logic [DW-1:0] old_val,
                                                  input logic [DW-1:0] new_val,
                                                  input logic [BW-1:0] lanes);
        logic [DW-1:0] r;
        r = old_val;
        for (int i = 0; i < BW; i++) begin
            if (lanes[i]) r[i*8 +: 8] = new_val[i*8 +: 8];
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] sat_inc(input logic [DW-1:0] v);
        return (&v) ? v : v + DW'(1);
    endfunction

    assign busy       = (state != ST_IDLE);
    assign wr_ctrl    = AVS_AVALONSLAVE_WRITE && (AVS_AVALONSLAVE_ADDRESS == ADDR_CTRL);
    assign wr_status  = AVS_AVALONSLAVE_WRITE && (AVS_AVALONSLAVE_ADDRESS == ADDR_STATUS);
    assign operand_wr = AVS_AVALONSLAVE_WRITE && !busy;
    assign start_req  = wr_ctrl && AVS_AVALONSLAVE_BYTEENABLE[0]
                        && AVS_AVALONSLAVE_WRITEDATA[0] && (state == ST_IDLE);
    assign done_hit   = (state == ST_BUSY) && DONE;
    assign status_w1c = wr_status && AVS_AVALONSLAVE_BYTEENABLE[0] && AVS_AVALONSLAVE_WRITEDATA[1];

    always_comb begin
        rd_mux = '0;
        case (AVS_AVALONSLAVE_ADDRESS)
            ADDR_CTRL:   rd_mux[1] = irq_en;
            ADDR_STATUS: begin
                rd_mux[0] = busy;
                rd_mux[1] = done_sticky;
            end
            ADDR_SRC_A:  rd_mux = src_a;
            ADDR_SRC_B:  rd_mux = src_b;
            ADDR_DST:    rd_mux = dst;
            ADDR_SIZE:   rd_mux[SIZE_W-1:0] = size_reg;
            ADDR_NUMBER: rd_mux[NUMBER_W-1:0] = number_reg;
            ADDR_CYCLES: rd_mux = cycles;
            default:     rd_mux = '0;
        endcase
    end

    // Run sequencer: GO is registered off the START state, so it lands one cycle after START.
    always_ff @(posedge CSI_CLOCK_CLK) begin
        if (CSI_CLOCK_RESET) begin
            state  <= ST_IDLE;
            cycles <= '0;
            go_reg <= 1'b0;
        end else begin
            go_reg <= (state == ST_START);
            case (state)
                ST_IDLE: begin
                    if (start_req) begin
                        state  <= ST_START;
                        cycles <= '0;
                    end
                end
                ST_START: state <= ST_BUSY;
                ST_BUSY: begin
                    cycles <= sat_inc(cycles);
                    if (DONE) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Completion set takes priority over a same-cycle write-one-to-clear.
    always_ff @(posedge CSI_CLOCK_CLK) begin
        if (CSI_CLOCK_RESET) begin
            irq_en      <= 1'b0;
            done_sticky <= 1'b0;
            irq_reg     <= 1'b0;
        end else begin
            if (wr_ctrl && AVS_AVALONSLAVE_BYTEENABLE[0]) irq_en <= AVS_AVALONSLAVE_WRITEDATA[1];
            if (done_hit)
                done_sticky <= 1'b1;
            else if (start_req || status_w1c)
                done_sticky <= 1'b0;
            irq_reg <= done_sticky && irq_en;
        end
    end

    always_ff @(posedge CSI_CLOCK_CLK) begin
        if (CSI_CLOCK_RESET) begin
            src_a      <= '0;
            src_b      <= '0;
            dst        <= '0;
            size_reg   <= '0;
            number_reg <= '0;
        end else if (operand_wr) begin
            case (AVS_AVALONSLAVE_ADDRESS)
                ADDR_SRC_A:  src_a <= merge_lanes(src_a, AVS_AVALONSLAVE_WRITEDATA,
                                                  AVS_AVALONSLAVE_BYTEENABLE);
                ADDR_SRC_B:  src_b <= merge_lanes(src_b, AVS_AVALONSLAVE_WRITEDATA,
                                                  AVS_AVALONSLAVE_BYTEENABLE);
                ADDR_DST:    dst <= merge_lanes(dst, AVS_AVALONSLAVE_WRITEDATA,
                                                AVS_AVALONSLAVE_BYTEENABLE);
                ADDR_SIZE:   size_reg <= SIZE_W'(merge_lanes(DW'(size_reg),
                                                AVS_AVALONSLAVE_WRITEDATA,
                                                AVS_AVALONSLAVE_BYTEENABLE));
                ADDR_NUMBER: number_reg <= NUMBER_W'(merge_lanes(DW'(number_reg),
                                                AVS_AVALONSLAVE_WRITEDATA,
                                                AVS_AVALONSLAVE_BYTEENABLE));
                default: ;
            endcase
        end
    end

    // Read data captures the pre-write register view and holds until the next read.
    always_ff @(posedge CSI_CLOCK_CLK) begin
        if (CSI_CLOCK_RESET)
            readdata <= '0;
        else if (AVS_AVALONSLAVE_READ)
            readdata <= rd_mux;
    end

    assign AVS_AVALONSLAVE_READDATA    = readdata;
    assign AVS_AVALONSLAVE_WAITREQUEST = 1'b0;
    assign INS_IRQ_IRQ                 = irq_reg;
    assign GO                          = go_reg;
    assign SLV_REG1                    = src_a;
    assign SLV_REG2                    = src_b;
    assign SLV_REG3                    = dst;
    assign SIZE                        = size_reg;
    assign NUMBER                      = number_reg;

endmodule

// File: tb/tb_avs_avalonslave_control.sv
// Directed plus randomized bench for the accelerator CSR slave, checked against a register-level model.
module tb_avs_avalonslave_control;

    logic        clk;
    logic        rst;
    logic [2:0]  addr;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        waitreq;
    logic        irq;
    logic        go;
    logic        done;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [31:0] reg3;
    logic [18:0] size;
    logic [10:0] number;

    int total = 0;
    int bad = 0;
    int edge_n = 0;
    int start_edge = -10;

    logic [31:0] mreg [8];
    logic        m_irq_en;
    logic        m_sticky;
    logic        m_busy;
    logic        m_irq;
    logic [31:0] m_cycles;

    avs_avalonslave_control dut (
        .CSI_CLOCK_CLK               (clk),
        .CSI_CLOCK_RESET             (rst),
        .AVS_AVALONSLAVE_ADDRESS     (addr),
        .AVS_AVALONSLAVE_READ        (rd),
        .AVS_AVALONSLAVE_WRITE       (wr),
        .AVS_AVALONSLAVE_WRITEDATA   (wdata),
        .AVS_AVALONSLAVE_BYTEENABLE  (be),
        .AVS_AVALONSLAVE_READDATA    (rdata),
        .AVS_AVALONSLAVE_WAITREQUEST (waitreq),
        .INS_IRQ_IRQ                 (irq),
        .GO                          (go),
        .DONE                        (done),
        .SLV_REG1                    (reg1),
        .SLV_REG2                    (reg2),
        .SLV_REG3                    (reg3),
        .SIZE                        (size),
        .NUMBER                      (number)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] b);
        logic [31:0] m;
        m = 32'h0;
        for (int i = 0; i < 4; i++) if (b[i]) m = m | (32'hFF << (8 * i));
        return m;
    endfunction

    function automatic logic [31:0] width_mask(input int a);
        if (a == 5) return 32'h0007_FFFF;
        if (a == 6) return 32'h0000_07FF;
        return 32'hFFFF_FFFF;
    endfunction

    // Value the DUT would capture if a read were sampled at the coming edge.
    function automatic logic [31:0] model_read(input int a);
        int n;
        case (a)
            0: return {30'b0, m_irq_en, 1'b0};
            1: return {30'b0, m_sticky, m_busy};
            7: begin
                if (!m_busy) return m_cycles;
                n = edge_n - start_edge - 1;
                return (n < 0) ? 32'd0 : 32'(n);
            end
            default: return mreg[a];
        endcase
    endfunction

    task automatic model_write(input int a, input logic [31:0] d, input logic [3:0] b);
        logic [31:0] lm;
        lm = lane_mask(b);
        if (a == 0) begin
            if (b[0]) begin
                m_irq_en = d[1];
                if (d[0] && !m_busy) begin
                    m_busy = 1'b1;
                    m_sticky = 1'b0;
                    m_cycles = 32'd0;
                    start_edge = edge_n;
                end
            end
        end else if (a == 1) begin
            if (b[0] && d[1]) m_sticky = 1'b0;
        end else if (a >= 2 && a <= 6 && !m_busy) begin
            mreg[a] = ((mreg[a] & ~lm) | (d & lm)) & width_mask(a);
        end
    endtask

    task automatic tick();
        logic pending;
        pending = m_sticky & m_irq_en;
        @(posedge clk);
        #1;
        edge_n++;
        m_irq = pending;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) mreg[i] = 32'd0;
        m_irq_en = 1'b0;
        m_sticky = 1'b0;
        m_busy = 1'b0;
        m_irq = 1'b0;
        m_cycles = 32'd0;
        start_edge = -10;
    endtask

    task automatic do_write(input int a, input logic [31:0] d, input logic [3:0] b);
        addr = 3'(a);
        wdata = d;
        be = b;
        wr = 1'b1;
        tick();
        wr = 1'b0;
        be = 4'h0;
        model_write(a, d, b);
    endtask

    task automatic do_read(input int a, input string tag);
        logic [31:0] exp;
        exp = model_read(a);
        addr = 3'(a);
        rd = 1'b1;
        tick();
        rd = 1'b0;
        chk(tag, rdata, exp);
    endtask

    task automatic do_rw(input int a, input logic [31:0] d, input logic [3:0] b);
        logic [31:0] exp;
        exp = model_read(a);
        addr = 3'(a);
        wdata = d;
        be = b;
        rd = 1'b1;
        wr = 1'b1;
        tick();
        rd = 1'b0;
        wr = 1'b0;
        be = 4'h0;
        model_write(a, d, b);
        chk("rw_prewrite", rdata, exp);
    endtask

    // GO is expected only in the second cycle after the START write is sampled.
    task automatic chk_go();
        chk("go", 32'(go), 32'(edge_n == start_edge + 1));
    endtask

    task automatic wait_until(input int target);
        while (edge_n < target) begin
            tick();
            chk_go();
        end
    endtask

    task automatic start_run(input logic [31:0] ctrl);
        do_write(0, ctrl, 4'h1);
        chk_go();
        wait_until(start_edge + 2);
    endtask

    task automatic done_pulse(input bit w1c);
        done = 1'b1;
        if (w1c) begin
            addr = 3'd1;
            wdata = 32'h2;
            be = 4'h1;
            wr = 1'b1;
        end
        tick();
        done = 1'b0;
        wr = 1'b0;
        be = 4'h0;
        if (w1c) model_write(1, 32'h2, 4'h1);
        if (m_busy && edge_n >= start_edge + 2) begin
            m_busy = 1'b0;
            m_sticky = 1'b1;
            m_cycles = 32'(edge_n - start_edge - 1);
        end
    endtask

    task automatic chk_ports();
        chk("slv_reg1", reg1, mreg[2]);
        chk("slv_reg2", reg2, mreg[3]);
        chk("slv_reg3", reg3, mreg[4]);
        chk("size_port", 32'(size), mreg[5]);
        chk("number_port", 32'(number), mreg[6]);
        chk("irq", 32'(irq), 32'(m_irq));
        chk("waitrequest", 32'(waitreq), 32'd0);
    endtask

    initial begin
        int s;
        int k;
        int a;
        rst = 1'b1;
        addr = 3'd0;
        rd = 1'b0;
        wr = 1'b0;
        wdata = 32'd0;
        be = 4'h0;
        done = 1'b0;
        do_reset();
        do_reset();

        chk("reset_readdata", rdata, 32'd0);
        chk("reset_go", 32'(go), 32'd0);
        chk_ports();
        for (int i = 0; i < 8; i++) do_read(i, "reset_csr");

        do_write(2, 32'h1000, 4'hF);
        do_write(3, 32'h2000, 4'hF);
        do_write(4, 32'h3000, 4'hF);
        do_write(5, 32'd16, 4'hF);
        do_write(6, 32'd2, 4'hF);
        for (int i = 2; i <= 6; i++) do_read(i, "operand_rb");
        chk("slv_reg1_const", reg1, 32'h1000);
        chk("size_const", 32'(size), 32'd16);
        chk_ports();

        do_write(2, 32'hFFFF_FFFF, 4'b0010);
        do_read(2, "lane_merge");
        chk("lane_merge_const", rdata, 32'h0000_FF00);
        do_write(2, 32'h1000, 4'hF);

        start_run(32'h3);
        s = start_edge;
        wait_until(s + 5);
        do_read(1, "status_busy");
        chk("status_busy_const", rdata, 32'h1);
        wait_until(s + 10);
        done_pulse(1'b0);
        do_read(1, "status_done");
        chk("status_done_const", rdata, 32'h2);
        do_read(7, "cycles");
        chk("cycles_const", rdata, 32'd10);
        chk("irq_after_done", 32'(irq), 32'd1);
        chk_ports();

        start_run(32'h3);
        s = start_edge;
        wait_until(s + 3);
        do_write(5, 32'd99, 4'hF);
        do_write(0, 32'h1, 4'h1);
        wait_until(s + 8);
        do_read(5, "size_locked");
        chk("size_locked_const", 32'(size), 32'd16);
        do_read(7, "cycles_running");
        done_pulse(1'b0);
        do_read(0, "ctrl_irq_en");
        chk_ports();

        start_run(32'h3);
        s = start_edge;
        wait_until(s + 5);
        done_pulse(1'b1);
        do_read(1, "status_set_wins");
        chk("status_set_wins_const", rdata, 32'h2);
        chk("irq_set", 32'(irq), 32'd1);
        do_write(1, 32'h2, 4'h1);
        chk("irq_hold", 32'(irq), 32'(m_irq));
        tick();
        chk("irq_drop", 32'(irq), 32'(m_irq));
        chk("irq_drop_const", 32'(irq), 32'd0);
        do_read(1, "status_cleared");

        do_rw(3, 32'hDEAD_BEEF, 4'hF);
        do_read(3, "rw_postwrite");

        for (int i = 0; i < 24; i++) begin
            a = $urandom_range(2, 6);
            do_write(a, $urandom, 4'($urandom_range(0, 15)));
            do_read(a, "rand_rb");
        end
        chk_ports();

        for (int r = 0; r < 3; r++) begin
            k = $urandom_range(4, 25);
            start_run(32'h1 | (32'($urandom_range(0, 1)) << 1));
            s = start_edge;
            wait_until(s + 2);
            do_write($urandom_range(2, 6), $urandom, 4'hF);
            wait_until(s + k);
            done_pulse(1'b0);
            do_read(7, "rand_cycles");
            do_read(1, "rand_status");
            tick();
            chk_ports();
        end

        start_run(32'h3);
        s = start_edge;
        wait_until(s + 4);
        do_reset();
        chk("abort_go", 32'(go), 32'd0);
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        do_read(1, "abort_status");
        chk("abort_status_const", rdata, 32'd0);
        for (int i = 0; i < 8; i++) do_read(i, "abort_csr");
        chk("abort_irq", 32'(irq), 32'd0);
        chk_ports();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
